// File: rtl/score_point.sv
// rtl/score_point.sv - score point: joins incoming intervals, waits for an optional user trigger, commands outgoing intervals
module score_point #(
    parameter int WIDTH = 32,
    parameter int N_IN  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] global_clock,
    input  logic             is_interactive,
    input  logic             trigger,
    input  logic             kill_req,
    input  logic [N_IN-1:0]  in_min_elapsed,
    input  logic [N_IN-1:0]  in_finished,
    input  logic [N_IN-1:0]  in_skip,
    input  logic [N_IN-1:0]  in_kill,
    output logic             ext_e,
    output logic             out_start,
    output logic             out_skip_p,
    output logic             out_kill_p,
    output logic             armed,
    output logic [WIDTH-1:0] fire_time
);

    localparam logic [5:0] S_WAIT    = 6'b000001;
    localparam logic [5:0] S_ARMED   = 6'b000010;
    localparam logic [5:0] S_EMIT    = 6'b000100;
    localparam logic [5:0] S_FIRED   = 6'b001000;
    localparam logic [5:0] S_SKIPPED = 6'b010000;
    localparam logic [5:0] S_KILLED  = 6'b100000;

    logic [5:0]       state_q, state_d;
    logic [N_IN-1:0]  min_q, min_d;
    logic [N_IN-1:0]  done_q, done_d;
    logic [N_IN-1:0]  fin_q, fin_d;
    logic [WIDTH-1:0] fire_time_q, fire_time_d;

    logic all_min, all_done, any_fin, kill_any, live;

    // Current-cycle pulses count alongside the sticky flags so a decision lands one edge after its input.
    assign all_min  = &(min_q | done_q | in_min_elapsed | in_finished | in_skip);
    assign all_done = &(done_q | in_finished | in_skip | in_kill);
    assign any_fin  = |(fin_q | in_finished);
    assign kill_any = kill_req | (|in_kill);
    assign live     = state_q[0] | state_q[1] | state_q[2];

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT, S_ARMED, S_EMIT: begin
                if (kill_any) begin
                    state_d = S_KILLED;
                end else if (all_done) begin
                    state_d = any_fin ? S_FIRED : S_SKIPPED;
                end else if ((state_q == S_WAIT) && is_interactive && all_min) begin
                    state_d = S_ARMED;
                end else if ((state_q == S_ARMED) && trigger) begin
                    state_d = S_EMIT;
                end
            end
            S_FIRED, S_SKIPPED, S_KILLED: state_d = state_q;
            default: state_d = S_WAIT;
        endcase
    end

    always_comb begin
        min_d       = min_q;
        done_d      = done_q;
        fin_d       = fin_q;
        fire_time_d = fire_time_q;
        if (live) begin
            min_d  = min_q | in_min_elapsed;
            done_d = done_q | in_finished | in_skip | in_kill;
            fin_d  = fin_q | in_finished;
            if (state_d == S_FIRED) begin
                fire_time_d = global_clock;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_WAIT;
            min_q       <= '0;
            done_q      <= '0;
            fin_q       <= '0;
            fire_time_q <= '0;
        end else begin
            state_q     <= state_d;
            min_q       <= min_d;
            done_q      <= done_d;
            fin_q       <= fin_d;
            fire_time_q <= fire_time_d;
        end
    end

    // Outputs are straight decodes of the one-hot state flops, so they are glitch-free registers.
    assign armed      = state_q[1];
    assign ext_e      = state_q[2];
    assign out_start  = state_q[3];
    assign out_skip_p = state_q[4];
    assign out_kill_p = state_q[5];
    assign fire_time  = fire_time_q;

endmodule

// File: tb/tb_score_point.sv
// tb/tb_score_point.sv - scoreboard bench for score_point with directed scenarios and randomized episodes
module tb_score_point;

    localparam int W = 32;
    localparam int N = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] global_clock = '0;
    logic         is_interactive = 1'b0;
    logic         trigger = 1'b0;
    logic         kill_req = 1'b0;
    logic [N-1:0] in_min_elapsed = '0;
    logic [N-1:0] in_finished = '0;
    logic [N-1:0] in_skip = '0;
    logic [N-1:0] in_kill = '0;
    logic         ext_e, out_start, out_skip_p, out_kill_p, armed;
    logic [W-1:0] fire_time;

    score_point #(.WIDTH(W), .N_IN(N)) dut (
        .clk(clk), .rst(rst), .global_clock(global_clock),
        .is_interactive(is_interactive), .trigger(trigger), .kill_req(kill_req),
        .in_min_elapsed(in_min_elapsed), .in_finished(in_finished),
        .in_skip(in_skip), .in_kill(in_kill),
        .ext_e(ext_e), .out_start(out_start), .out_skip_p(out_skip_p),
        .out_kill_p(out_kill_p), .armed(armed), .fire_time(fire_time)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int tnow = 0;

    typedef enum {P_WAIT, P_ARMED, P_EMIT, P_FIRED, P_SKIPPED, P_KILLED} phase_t;
    phase_t       ph = P_WAIT;
    bit           seen_min[N];
    bit           seen_done[N];
    bit           seen_fin[N];
    logic [W-1:0] m_ft = '0;

    logic [W+4:0] exp_q[$];

    function automatic logic [W+4:0] expected_outputs();
        return {ph == P_EMIT, ph == P_ARMED, ph == P_FIRED, ph == P_SKIPPED, ph == P_KILLED, m_ft};
    endfunction

    function automatic logic [W+4:0] actual_outputs();
        return {ext_e, armed, out_start, out_skip_p, out_kill_p, fire_time};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0d)", name, act, exp, tnow);
        end
    endtask

    task automatic model_clear();
        ph   = P_WAIT;
        m_ft = '0;
        for (int i = 0; i < N; i++) begin
            seen_min[i] = 0; seen_done[i] = 0; seen_fin[i] = 0;
        end
    endtask

    // Reference: what the point should be doing after the coming clock edge.
    task automatic model_step(input bit r, input bit inter, input bit trg, input bit kr,
                              input logic [N-1:0] mn, input logic [N-1:0] fn,
                              input logic [N-1:0] sk, input logic [N-1:0] kl,
                              input logic [W-1:0] gc);
        bit every_min, every_done, some_fin, killed;
        if (r) begin
            model_clear();
            return;
        end
        if (!(ph inside {P_WAIT, P_ARMED, P_EMIT})) return;
        every_min = 1; every_done = 1; some_fin = 0; killed = kr;
        for (int i = 0; i < N; i++) begin
            if (!(seen_min[i] || seen_done[i] || mn[i] || fn[i] || sk[i])) every_min = 0;
            if (!(seen_done[i] || fn[i] || sk[i] || kl[i])) every_done = 0;
            if (seen_fin[i] || fn[i]) some_fin = 1;
            if (kl[i]) killed = 1;
        end
        if (killed) ph = P_KILLED;
        else if (every_done) begin
            if (some_fin) begin
                ph   = P_FIRED;
                m_ft = gc;
            end else ph = P_SKIPPED;
        end else if (ph == P_WAIT && inter && every_min) ph = P_ARMED;
        else if (ph == P_ARMED && trg) ph = P_EMIT;
        for (int i = 0; i < N; i++) begin
            if (mn[i]) seen_min[i] = 1;
            if (fn[i] || sk[i] || kl[i]) seen_done[i] = 1;
            if (fn[i]) seen_fin[i] = 1;
        end
    endtask

    task automatic drive(input bit r, input bit inter, input bit trg, input bit kr,
                         input logic [N-1:0] mn, input logic [N-1:0] fn,
                         input logic [N-1:0] sk, input logic [N-1:0] kl);
        @(negedge clk);
        rst = r; is_interactive = inter; trigger = trg; kill_req = kr;
        in_min_elapsed = mn; in_finished = fn; in_skip = sk; in_kill = kl;
        global_clock = W'(tnow);
        model_step(r, inter, trg, kr, mn, fn, sk, kl, W'(tnow));
        exp_q.push_back(expected_outputs());
        tnow++;
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, '0, '0, '0, '0);
        drive(1, 0, 0, 0, '0, '0, '0, '0);
        tnow = 0;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    // Reset asserted between edges must clear outputs without waiting for a clock.
    task automatic async_reset_check(input string name);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check(name, 64'(actual_outputs()), 64'd0);
        model_clear();
    endtask

    task automatic static_run(input int t_a, input int t_b);
        for (int t = 0; t <= t_b + 3; t++)
            drive(0, 0, 0, 0, '0, (t == t_a) ? 2'b01 : (t == t_b) ? 2'b10 : 2'b00, '0, '0);
    endtask

    initial begin : monitor
        logic [W+4:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("scoreboard {ext_e,armed,start,skip,kill,fire_time}", 64'(actual_outputs()), 64'(e));
            end
        end
    end

    initial begin : stimulus
        bit inter;
        int len;
        #1;
        check("reset outputs", 64'(actual_outputs()), 64'd0);

        // Static point fires when both inputs have finished.
        do_reset();
        static_run(10, 15);
        after_edge();
        check("static fire_time", 64'(fire_time), 64'd15);
        check("static out_start", 64'(out_start), 64'd1);

        // Interactive: arm, trigger, finish.
        do_reset();
        for (int t = 0; t <= 13; t++)
            drive(0, 1, t == 9, 0, (t == 5) ? 2'b11 : 2'b00, (t == 10) ? 2'b11 : 2'b00, '0, '0);
        after_edge();
        check("interactive fired", 64'({out_start, ext_e}), 64'b10);

        // Early trigger ignored; later trigger emits.
        do_reset();
        for (int t = 0; t <= 11; t++)
            drive(0, 1, (t == 3) || (t == 8), 0, (t == 5) ? 2'b11 : 2'b00, '0, '0, '0);
        after_edge();
        check("emit after late trigger", 64'({ext_e, armed}), 64'b10);
        async_reset_check("async reset mid-EMIT");

        // All skipped -> skip; skip plus finish -> fire.
        do_reset();
        for (int t = 0; t <= 7; t++)
            drive(0, 0, 0, 0, '0, '0, (t == 4) ? 2'b11 : 2'b00, '0);
        after_edge();
        check("all skipped", 64'({out_skip_p, out_start, fire_time}), {32'd0, 2'b10, 32'd0});
        do_reset();
        for (int t = 0; t <= 7; t++)
            drive(0, 0, 0, 0, '0, (t == 4) ? 2'b10 : 2'b00, (t == 4) ? 2'b01 : 2'b00, '0);
        after_edge();
        check("skip+finish fires", 64'({out_start, fire_time}), {31'd0, 1'b1, 32'd4});

        // Finish and kill together in EMIT: kill wins.
        do_reset();
        for (int t = 0; t <= 9; t++)
            drive(0, 1, t == 3, 0, (t == 1) ? 2'b11 : 2'b00, (t == 6) ? 2'b01 : 2'b00,
                  '0, (t == 6) ? 2'b10 : 2'b00);
        after_edge();
        check("kill beats finish", 64'({out_kill_p, out_start}), 64'b10);

        // Reset in FIRED, then a fresh sequence fires with a new time.
        do_reset();
        static_run(2, 3);
        async_reset_check("async reset in FIRED");
        tnow = 0;
        static_run(6, 12);
        after_edge();
        check("refire fire_time", 64'(fire_time), 64'd12);

        // Randomized episodes against the reference model.
        for (int ep = 0; ep < 80; ep++) begin
            do_reset();
            inter = 1'($urandom_range(0, 1));
            len   = $urandom_range(8, 40);
            for (int c = 0; c < len; c++) begin
                logic [N-1:0] mn, fn, sk, kl;
                for (int i = 0; i < N; i++) begin
                    mn[i] = ($urandom_range(0, 5) == 0);
                    fn[i] = ($urandom_range(0, 11) == 0);
                    sk[i] = ($urandom_range(0, 15) == 0);
                    kl[i] = ($urandom_range(0, 60) == 0);
                end
                if ($urandom_range(0, 15) == 0) inter = ~inter;
                drive(0, inter, $urandom_range(0, 3) == 0, $urandom_range(0, 80) == 0, mn, fn, sk, kl);
            end
            if ($urandom_range(0, 9) == 0) async_reset_check("async reset random");
        end

        after_edge();
        after_edge();
        check("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
